// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell sequenced LSB-first
// over WIDTH cycles behind a start/ready/done handshake.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s, cell_co;
  logic             last;

  serial_adder_fa u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          sum_sh <= '0;
          carry  <= cin;
          cnt    <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
          carry  <= cell_co;
          if (last) begin
            // On the MSB step the carry register holds the carry into the MSB,
            // so overflow is that carry against the cell's carry-out.
            sum  <= {cell_s, sum_sh[WIDTH-1:1]};
            cout <= cell_co;
            ovf  <= carry ^ cell_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH 8, plus operand sweeps at
// WIDTH 2 (exhaustive) and WIDTH 32 (random).

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st8, ci8, rdy8, bsy8, dn8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        st2, ci2, rdy2, bsy2, dn2, co2, ov2;
  logic [1:0]  a2, b2, s2;
  logic        st32, ci32, rdy32, bsy32, dn32, co32, ov32;
  logic [31:0] a32, b32, s32;

  int nassert = 0;
  int nfail   = 0;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .sum(s8), .cout(co8), .ovf(ov8));
  serial_adder_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(ci2),
    .ready(rdy2), .busy(bsy2), .done(dn2), .sum(s2), .cout(co2), .ovf(ov2));
  serial_adder_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(st32), .a(a32), .b(b32), .cin(ci32),
    .ready(rdy32), .busy(bsy32), .done(dn32), .sum(s32), .cout(co32), .ovf(ov32));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tci, input logic [7:0] es, input logic eco, input logic eov);
    int n, guard;
    a8 = ta; b8 = tb; ci8 = tci; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    n = 0; guard = 0;
    while (!dn8 && guard < 40) begin
      if (bsy8) n++;
      guard++;
      tick();
    end
    check({tag, " done"}, 64'(dn8), 64'd1);
    check({tag, " busy_cycles"}, 64'(n), 64'd8);
    check({tag, " sum"}, 64'(s8), 64'(es));
    check({tag, " cout"}, 64'(co8), 64'(eco));
    check({tag, " ovf"}, 64'(ov8), 64'(eov));
    tick();
    check({tag, " ready_after"}, 64'({rdy8, bsy8, dn8}), 64'b100);
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tci);
    int n;
    logic [2:0] ex;
    logic       eov;
    ex  = 3'(ta) + 3'(tb) + 3'(tci);
    eov = (ta[1] == tb[1]) && (ex[1] != ta[1]);
    a2 = ta; b2 = tb; ci2 = tci; st2 = 1'b1;
    tick();
    st2 = 1'b0;
    n = 0;
    while (!dn2 && n < 20) begin n++; tick(); end
    check("w2 latency", 64'(n), 64'd2);
    check("w2 sum", 64'(s2), 64'(ex[1:0]));
    check("w2 cout", 64'(co2), 64'(ex[2]));
    check("w2 ovf", 64'(ov2), 64'(eov));
    tick();
  endtask

  task automatic op32(input logic [31:0] ta, input logic [31:0] tb, input logic tci);
    int n;
    logic [32:0] ex;
    logic        eov;
    ex  = 33'(ta) + 33'(tb) + 33'(tci);
    eov = (ta[31] == tb[31]) && (ex[31] != ta[31]);
    a32 = ta; b32 = tb; ci32 = tci; st32 = 1'b1;
    tick();
    st32 = 1'b0;
    n = 0;
    while (!dn32 && n < 60) begin n++; tick(); end
    check("w32 latency", 64'(n), 64'd32);
    check("w32 sum", 64'(s32), 64'(ex[31:0]));
    check("w32 cout", 64'(co32), 64'(ex[32]));
    check("w32 ovf", 64'(ov32), 64'(eov));
    tick();
  endtask

  initial begin
    int n, k, t;
    int tm [3];
    logic seen_ready;

    rst = 1'b1;
    st8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    st2 = 0; a2 = 0; b2 = 0; ci2 = 0;
    st32 = 0; a32 = 0; b32 = 0; ci32 = 0;
    #2;
    check("reset w8 flags", 64'({rdy8, bsy8, dn8}), 64'b100);
    check("reset w8 outs", 64'({s8, co8, ov8}), 64'd0);
    check("reset w2 flags", 64'({rdy2, bsy2, dn2}), 64'b100);
    check("reset w32 outs", 64'({s32, co32, ov32}), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    op8("basic",      8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("ripple",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("cin_only",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    op8("ovf_pos",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("ovf_neg",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("full",       8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // starts during RUN and DONE must be ignored
    a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    tick(); tick();
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1; st8 = 1'b1;
    n = 0; seen_ready = 1'b0;
    while (!dn8 && n < 40) begin
      seen_ready |= rdy8;
      n++;
      tick();
    end
    check("ign done", 64'(dn8), 64'd1);
    check("ign ready_low", 64'(seen_ready | rdy8), 64'd0);
    check("ign sum", 64'({co8, s8}), 64'h010);
    tick();
    st8 = 1'b0;
    check("ign idle_after", 64'({rdy8, bsy8, dn8}), 64'b100);
    tick();
    check("ign not_accepted", 64'({rdy8, bsy8, dn8}), 64'b100);
    check("ign sum_hold", 64'(s8), 64'h10);

    // leave nonzero sum/cout/ovf, then reset mid-run
    op8("pre_rst", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("midrst flags", 64'({rdy8, bsy8, dn8}), 64'b100);
    check("midrst outs", 64'({s8, co8, ov8}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    op8("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // start held high: three back-to-back additions
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; st8 = 1'b1;
    k = 0; t = 0;
    while (k < 3 && t < 60) begin
      tick();
      t++;
      if (dn8) begin
        tm[k] = t;
        k++;
      end
    end
    st8 = 1'b0;
    check("b2b count", 64'(k), 64'd3);
    check("b2b gap1", 64'(tm[1] - tm[0]), 64'd10);
    check("b2b gap2", 64'(tm[2] - tm[1]), 64'd10);
    check("b2b sum", 64'({co8, s8}), 64'h047);
    tick(); tick();
    check("b2b idle", 64'({rdy8, bsy8, dn8}), 64'b100);

    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          op2(2'(ia), 2'(ib), 1'(ic));

    op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 20; i++)
      op32($urandom, $urandom, 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
